// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array datapath blocks.
// Provides the default vector geometry and the helper that sizes the
// fill counter of the collector so that it can represent 0..LENGTH.
package sa_pkg;

  localparam int DEFAULT_LENGTH    = 32;
  localparam int DEFAULT_BIT_WIDTH = 16;
  localparam int SHORT_LENGTH      = 8;

  // Counter must hold the value LENGTH itself (the stalled state), hence +1.
  function automatic int cnt_width(input int length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/collect_hold_reg.sv
// Output stage of deserialize_collect: one holding register with a
// valid/ready handshake towards the consumer.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   load        capture load_data this cycle (asserts out_valid)
//   load_data   vector to capture
//   out_ready   consumer takes the vector this cycle
//   out_valid   hold register contains a complete vector
//   out         held vector; keeps its last value after being consumed
//   hold_free   hold can accept a new vector this cycle
module collect_hold_reg #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             hold_free
);

  // The hold is free either when empty or when its vector leaves this cycle,
  // which lets a new vector replace the old one without a bubble.
  assign hold_free = !out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out       <= load_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/deserialize_collect.sv
// Collects BIT_WIDTH result words from an array output column and packs
// LENGTH of them into one parallel vector (first word in the MSB slot).
// A shift register assembles the next vector while the hold stage drains
// the previous one.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   in_valid    a word is present on in
//   in          serial result word
//   in_ready    block accepts a word this cycle (registered state only)
//   out_valid   hold register contains a complete vector
//   out         assembled vector
//   out_ready   consumer takes the vector this cycle
//   fill        words currently in the shift register (0..LENGTH)
module deserialize_collect
  import sa_pkg::*;
#(
  parameter  int LENGTH    = DEFAULT_LENGTH,
  parameter  int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  localparam int CNT_W     = cnt_width(LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [BIT_WIDTH-1:0]        in,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [LENGTH*BIT_WIDTH-1:0] out,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            fill
);

  localparam int                VW   = LENGTH * BIT_WIDTH;
  localparam logic [CNT_W-1:0]  FULL = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(LENGTH - 1);

  logic [VW-1:0]    shift;
  logic [VW-1:0]    shifted;
  logic [VW-1:0]    load_data;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic             accept;
  logic             load;
  logic             hold_free;

  assign in_ready = (count != FULL);
  assign accept   = in_valid & in_ready;
  assign shifted  = {shift[(LENGTH-1)*BIT_WIDTH-1:0], in};
  assign fill     = count;

  // Two ways to hand a vector to the hold: straight from the completing word
  // (bypassing the shift register) or later from a full, stalled shift register.
  always_comb begin
    load       = 1'b0;
    load_data  = shifted;
    next_count = count;
    if (count == FULL) begin
      if (hold_free) begin
        load       = 1'b1;
        load_data  = shift;
        next_count = '0;
      end
    end else if (accept) begin
      if (count == LAST && hold_free) begin
        load       = 1'b1;
        next_count = '0;
      end else begin
        next_count = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      count <= '0;
    end else begin
      if (accept) shift <= shifted;
      count <= next_count;
    end
  end

  collect_hold_reg #(
    .WIDTH(VW)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out       (out),
    .hold_free (hold_free)
  );

endmodule

// File: tb/tb_deserialize_collect.sv
// Self-checking bench for deserialize_collect with LENGTH=4, BIT_WIDTH=16.
// A directed vector table, a few hand-written corner sequences and a
// randomized phase checked against a queue-based reference model.
module tb_deserialize_collect;

  localparam int L = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_word;
  logic          in_ready;
  logic          out_valid;
  logic [L*W-1:0] out_vec;
  logic          out_ready;
  logic [2:0]    fill;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic          iv;
    logic [W-1:0]  din;
    logic          ordy;
    logic          exp_ov;
    logic [L*W-1:0] exp_out;
    logic [2:0]    exp_fill;
    logic          exp_rdy;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [W-1:0]   pend[$];
  logic           m_hv;
  logic [L*W-1:0] m_hold;

  always #5 clk = ~clk;

  deserialize_collect #(
    .LENGTH   (L),
    .BIT_WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in_word),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out      (out_vec),
    .out_ready(out_ready),
    .fill     (fill)
  );

  // Drive one cycle of inputs, let the edge happen, settle past it.
  task automatic applyStimulus(input logic iv, input logic [W-1:0] d, input logic ordy);
    in_valid  = iv;
    in_word   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ov, input logic [L*W-1:0] ov_data,
                             input logic [2:0] f, input logic rdy);
    compared++;
    if (out_valid !== ov) begin
      mismatched++;
      $display("[TB] FAIL %s out_valid got %0b want %0b", name, out_valid, ov);
    end
    compared++;
    if (out_vec !== ov_data) begin
      mismatched++;
      $display("[TB] FAIL %s out got %h want %h", name, out_vec, ov_data);
    end
    compared++;
    if (fill !== f) begin
      mismatched++;
      $display("[TB] FAIL %s fill got %0d want %0d", name, fill, f);
    end
    compared++;
    if (in_ready !== rdy) begin
      mismatched++;
      $display("[TB] FAIL %s in_ready got %0b want %0b", name, in_ready, rdy);
    end
  endtask

  task automatic addRow(input logic iv, input logic [W-1:0] d, input logic ordy, input logic ov,
                        input logic [L*W-1:0] o, input logic [2:0] f, input logic rdy);
    vec_t r;
    r.iv = iv; r.din = d; r.ordy = ordy;
    r.exp_ov = ov; r.exp_out = o; r.exp_fill = f; r.exp_rdy = rdy;
    tbl.push_back(r);
  endtask

  // First word collected lands in the most significant slot.
  function automatic logic [L*W-1:0] packWords(input logic [W-1:0] w[$]);
    logic [L*W-1:0] v = '0;
    foreach (w[i]) v = {v[(L-1)*W-1:0], w[i]};
    return v;
  endfunction

  task automatic modelStep(input logic iv, input logic [W-1:0] d, input logic ordy);
    logic hf;
    hf = !m_hv || ordy;
    if (iv && pend.size() != L) pend.push_back(d);
    if (pend.size() == L && hf) begin
      m_hold = packWords(pend);
      pend.delete();
      m_hv = 1'b1;
    end else if (m_hv && ordy) begin
      m_hv = 1'b0;
    end
  endtask

  localparam logic [L*W-1:0] V1  = 64'h1111_2222_3333_4444;
  localparam logic [L*W-1:0] VA  = 64'hA001_A002_A003_A004;
  localparam logic [L*W-1:0] VB1 = 64'hB001_B002_B003_B004;
  localparam logic [L*W-1:0] VB2 = 64'hB005_B006_B007_B008;
  localparam logic [L*W-1:0] VC  = 64'hC001_C002_C003_C004;
  localparam logic [L*W-1:0] VF  = 64'hF001_F002_F003_F004;

  initial begin
    logic [L*W-1:0] cur;
    logic [L*W-1:0] rv;
    logic [W-1:0]   grp[$];
    logic           iv, ordy;
    logic [W-1:0]   d;

    // round trip, out_ready high
    addRow(1, 16'h1111, 1, 0, '0, 1, 1);
    addRow(1, 16'h2222, 1, 0, '0, 2, 1);
    addRow(1, 16'h3333, 1, 0, '0, 3, 1);
    addRow(1, 16'h4444, 1, 1, V1, 0, 1);
    addRow(0, 16'h0000, 1, 0, V1, 0, 1);
    // gapped input
    addRow(1, 16'hA001, 1, 0, V1, 1, 1);
    addRow(0, 16'hFFFF, 1, 0, V1, 1, 1);
    addRow(1, 16'hA002, 1, 0, V1, 2, 1);
    addRow(0, 16'hFFFF, 1, 0, V1, 2, 1);
    addRow(1, 16'hA003, 1, 0, V1, 3, 1);
    addRow(0, 16'hFFFF, 1, 0, V1, 3, 1);
    addRow(1, 16'hA004, 1, 1, VA, 0, 1);
    addRow(0, 16'h0000, 1, 0, VA, 0, 1);
    // back-pressure: 8 words with out_ready low
    addRow(1, 16'hB001, 0, 0, VA, 1, 1);
    addRow(1, 16'hB002, 0, 0, VA, 2, 1);
    addRow(1, 16'hB003, 0, 0, VA, 3, 1);
    addRow(1, 16'hB004, 0, 1, VB1, 0, 1);
    addRow(1, 16'hB005, 0, 1, VB1, 1, 1);
    addRow(1, 16'hB006, 0, 1, VB1, 2, 1);
    addRow(1, 16'hB007, 0, 1, VB1, 3, 1);
    addRow(1, 16'hB008, 0, 1, VB1, 4, 0);
    // stalled: 0xDEAD must be ignored, also on the draining cycle
    addRow(1, 16'hDEAD, 0, 1, VB1, 4, 0);
    addRow(1, 16'hDEAD, 1, 1, VB2, 0, 1);
    addRow(1, 16'hC001, 1, 0, VB2, 1, 1);
    addRow(1, 16'hC002, 1, 0, VB2, 2, 1);
    addRow(1, 16'hC003, 1, 0, VB2, 3, 1);
    addRow(1, 16'hC004, 1, 1, VC, 0, 1);
    // back-to-back: 12 words, in_ready never drops
    cur = VC;
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 3) begin
        cur = {16'(16'hD001 + k - 3), 16'(16'hD001 + k - 2), 16'(16'hD001 + k - 1), 16'(16'hD001 + k)};
        addRow(1, 16'(16'hD001 + k), 1, 1, cur, 0, 1);
      end else begin
        addRow(1, 16'(16'hD001 + k), 1, 0, cur, 3'((k % 4) + 1), 1);
      end
    end

    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
    #1;
    checkOutput("reset", 0, '0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].iv, tbl[i].din, tbl[i].ordy);
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp_ov, tbl[i].exp_out, tbl[i].exp_fill, tbl[i].exp_rdy);
    end

    // reset in the middle of a vector, asserted between edges
    applyStimulus(1, 16'hE001, 1);
    checkOutput("mid_pre1", 0, cur, 1, 1);
    applyStimulus(1, 16'hE002, 1);
    checkOutput("mid_pre2", 0, cur, 2, 1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_mid", 0, '0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1, 16'hF001, 1);
    applyStimulus(1, 16'hF002, 1);
    applyStimulus(1, 16'hF003, 1);
    checkOutput("after_reset3", 0, '0, 3, 1);
    applyStimulus(1, 16'hF004, 1);
    checkOutput("after_reset_vec", 1, VF, 0, 1);

    // serializer round trip: random vector split MSB word first
    rv = {$urandom, $urandom};
    for (int i = 0; i < L; i++) applyStimulus(1, rv[(L-1-i)*W +: W], 1);
    checkOutput("serdes_roundtrip", 1, rv, 0, 1);

    // randomized phase against the queue model
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pend.delete(); m_hv = 1'b0; m_hold = '0;
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = 16'($urandom);
      modelStep(iv, d, ordy);
      applyStimulus(iv, d, ordy);
      checkOutput($sformatf("rand[%0d]", c), m_hv, m_hold, 3'(pend.size()), pend.size() != L);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
